// File: rtl/serial_hba_pkg.sv
// Shared definitions for the serial-to-HBA protocol engine: FSM encodings,
// command byte field positions and the write acknowledge byte.
package serial_hba_pkg;

  // ST_ACK only exists when SERIAL_HBA_WRITE_ACK_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_BUS_REQ,
    ST_BUS_XFER,
    ST_TX
`ifdef SERIAL_HBA_WRITE_ACK_EN
    , ST_ACK
`endif
  } state_e;

  typedef enum logic [1:0] {
    XF_IDLE,
    XF_REQ,
    XF_XFER
  } xfer_phase_e;

  localparam int CMD_RNW_BIT   = 7;
  localparam int CMD_CNT_HI    = 6;
  localparam int CMD_CNT_LO    = 4;
  localparam int CMD_PERIPH_HI = 3;
  localparam int CMD_PERIPH_LO = 0;

  localparam logic [7:0] ACK_BYTE = 8'hAC;

  // Burst length N = 1..8 encoded as N-1 in the command byte.
  function automatic logic [3:0] cmd_burst_len(input logic [7:0] cmd);
    return {1'b0, cmd[CMD_CNT_HI:CMD_CNT_LO]} + 4'd1;
  endfunction

endpackage

// File: rtl/hba_master_xfer.sv
// Single-byte HBA master handshake: request, wait for grant, drive the
// transfer until xferack, then release everything back to zero.
module hba_master_xfer
  import serial_hba_pkg::*;
(
  input  logic        hba_clk,
  input  logic        hba_reset,
  input  logic        start,
  input  logic [11:0] addr,
  input  logic        rnw,
  input  logic [7:0]  wdata,
  output logic        done,
  output logic [7:0]  rdata,
  input  logic        hba_mgrant,
  input  logic        hba_xferack,
  input  logic [7:0]  hba_dbus,
  output logic        masterx_request,
  output logic [11:0] master_abus,
  output logic        master_rnw,
  output logic [7:0]  master_dbus
);

  xfer_phase_e phase_q, phase_d;
  logic        req_q, req_d;
  logic [11:0] abus_q, abus_d;
  logic        rnw_q, rnw_d;
  logic [7:0]  dbus_q, dbus_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    phase_d = phase_q;
    req_d   = req_q;
    abus_d  = abus_q;
    rnw_d   = rnw_q;
    dbus_d  = dbus_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    unique case (phase_q)
      XF_IDLE: begin
        if (start) begin
          phase_d = XF_REQ;
          req_d   = 1'b1;
        end
      end
      XF_REQ: begin
        // An xferack coinciding with the grant is deliberately ignored here.
        if (hba_mgrant) begin
          phase_d = XF_XFER;
          abus_d  = addr;
          rnw_d   = rnw;
          dbus_d  = rnw ? 8'h00 : wdata;
        end
      end
      XF_XFER: begin
        if (hba_xferack) begin
          phase_d = XF_IDLE;
          req_d   = 1'b0;
          abus_d  = '0;
          rnw_d   = 1'b0;
          dbus_d  = '0;
          done_d  = 1'b1;
          if (rnw_q) rdata_d = hba_dbus;
        end
      end
      default: phase_d = XF_IDLE;
    endcase
  end

  // NOTE: the async reset drops the bus request without waiting for a clock.
  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      phase_q <= XF_IDLE;
      req_q   <= 1'b0;
      abus_q  <= '0;
      rnw_q   <= 1'b0;
      dbus_q  <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      phase_q <= phase_d;
      req_q   <= req_d;
      abus_q  <= abus_d;
      rnw_q   <= rnw_d;
      dbus_q  <= dbus_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign done            = done_q;
  assign rdata           = rdata_q;
  assign masterx_request = req_q;
  assign master_abus     = abus_q;
  assign master_rnw      = rnw_q;
  assign master_dbus     = dbus_q;

endmodule

// File: rtl/serial_hba_master.sv
// Frame parser between the byte UART and the HBA master port.
// Optional write acknowledge (0xAC) enabled by SERIAL_HBA_WRITE_ACK_EN.
module serial_hba_master
  import serial_hba_pkg::*;
#(
  parameter int RX_TIMEOUT = 1_000_000
) (
  input  logic        hba_clk,
  input  logic        hba_reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rd,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        wr,
  input  logic        hba_mgrant,
  input  logic        hba_xferack,
  input  logic [7:0]  hba_dbus,
  output logic        masterx_request,
  output logic [11:0] master_abus,
  output logic        master_rnw,
  output logic [7:0]  master_dbus
);

  localparam int TW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

  state_e        state_q, state_d;
  logic          rnw_q, rnw_d;
  logic [3:0]    periph_q, periph_d;
  logic [7:0]    reg_q, reg_d;
  logic [3:0]    count_q, count_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic          accept;
  logic          timeout;
  logic          start;
  logic          xfer_done;
  logic [7:0]    xfer_rdata;

  // rd_q still high means the UART has not yet retired the byte just taken.
  assign accept  = rx_valid && !rd_q;
  assign timeout = (timer_q == TW'(RX_TIMEOUT - 1));
  assign start   = (state_d == ST_BUS_REQ) && (state_q != ST_BUS_REQ);

  always_comb begin
    state_d   = state_q;
    rnw_d     = rnw_q;
    periph_d  = periph_q;
    reg_d     = reg_q;
    count_d   = count_q;
    wdata_d   = wdata_q;
    timer_d   = '0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    tx_data_d = tx_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rd_d     = 1'b1;
          rnw_d    = rx_data[CMD_RNW_BIT];
          periph_d = rx_data[CMD_PERIPH_HI:CMD_PERIPH_LO];
          count_d  = cmd_burst_len(rx_data);
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (accept) begin
          rd_d    = 1'b1;
          reg_d   = rx_data;
          state_d = rnw_q ? ST_BUS_REQ : ST_WDATA;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WDATA: begin
        if (accept) begin
          rd_d    = 1'b1;
          wdata_d = rx_data;
          state_d = ST_BUS_REQ;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_BUS_REQ: begin
        if (hba_mgrant) state_d = ST_BUS_XFER;
      end
      ST_BUS_XFER: begin
        if (xfer_done) begin
          reg_d   = reg_q + 8'd1;
          count_d = count_q - 4'd1;
          if (rnw_q) begin
            tx_data_d = xfer_rdata;
            state_d   = ST_TX;
          end else if (count_q != 4'd1) begin
            state_d = ST_WDATA;
          end else begin
`ifdef SERIAL_HBA_WRITE_ACK_EN
            tx_data_d = ACK_BYTE;
            state_d   = ST_ACK;
`else
            state_d   = ST_IDLE;
`endif
          end
        end
      end
      ST_TX: begin
        if (!tx_busy && !wr_q) begin
          wr_d    = 1'b1;
          state_d = (count_q != 4'd0) ? ST_BUS_REQ : ST_IDLE;
        end
      end
`ifdef SERIAL_HBA_WRITE_ACK_EN
      ST_ACK: begin
        if (!tx_busy && !wr_q) begin
          wr_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      state_q   <= ST_IDLE;
      rnw_q     <= 1'b0;
      periph_q  <= '0;
      reg_q     <= '0;
      count_q   <= '0;
      wdata_q   <= '0;
      timer_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rnw_q     <= rnw_d;
      periph_q  <= periph_d;
      reg_q     <= reg_d;
      count_q   <= count_d;
      wdata_q   <= wdata_d;
      timer_q   <= timer_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      tx_data_q <= tx_data_d;
    end
  end

  hba_master_xfer u_xfer (
    .hba_clk         (hba_clk),
    .hba_reset       (hba_reset),
    .start           (start),
    .addr            ({periph_q, reg_q}),
    .rnw             (rnw_q),
    .wdata           (wdata_q),
    .done            (xfer_done),
    .rdata           (xfer_rdata),
    .hba_mgrant      (hba_mgrant),
    .hba_xferack     (hba_xferack),
    .hba_dbus        (hba_dbus),
    .masterx_request (masterx_request),
    .master_abus     (master_abus),
    .master_rnw      (master_rnw),
    .master_dbus     (master_dbus)
  );

  assign rd      = rd_q;
  assign wr      = wr_q;
  assign tx_data = tx_data_q;

endmodule
